coef_carry_normalizer: RTL and testbench

//  Downstream consumer of the adder-tree reduction stage. Takes NUM_COEFS

---
 rtl/coef_carry_normalizer_if.sv | 61 ++++++
 rtl/coef_carry_normalizer.sv | 161 ++++++++++++++++
 tb/tb_coef_carry_normalizer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_carry_normalizer_if.sv
// -----------------------------------------------------------------------------
// coef_carry_normalizer_if
//   Bundles both stream sides of the carry normalizer (operand input and
//   normalized result output) into one interface.
//
//   Signals
//     in_valid   producer -> block   in_coefs valid
//     in_ready   block -> producer   block can accept an operand
//     in_coefs   producer -> block   NUM_COEFS x BIT_LEN redundant coefficients
//     out_valid  block -> consumer   out_words/out_carry valid
//     out_ready  consumer -> block   consumer accepts result
//     out_words  block -> consumer   NUM_COEFS x WORD_LEN normalized words
//     out_carry  block -> consumer   value above the top word
//     out_passes block -> consumer   (CARRY_NORM_STATS_EN only) passes used
//     max_passes block -> consumer   (CARRY_NORM_STATS_EN only) running max
//
//   Modports
//     master : environment side (drives operands, accepts results)
//     slave  : normalizer side
//
//   Optional feature macro: CARRY_NORM_STATS_EN
// -----------------------------------------------------------------------------
interface coef_carry_normalizer_if #(
    parameter int NUM_COEFS = 8,
    parameter int BIT_LEN   = 24,
    parameter int WORD_LEN  = 16,
    parameter int CARRY_LEN = BIT_LEN - WORD_LEN + $clog2(NUM_COEFS)
);
    localparam int PASS_W = $clog2(NUM_COEFS + 2);

    logic                                 in_valid;
    logic                                 in_ready;
    logic [NUM_COEFS-1:0][BIT_LEN-1:0]    in_coefs;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [NUM_COEFS-1:0][WORD_LEN-1:0]   out_words;
    logic [CARRY_LEN-1:0]                 out_carry;
`ifdef CARRY_NORM_STATS_EN
    logic [PASS_W-1:0]                    out_passes;
    logic [PASS_W-1:0]                    max_passes;

    modport master (
        output in_valid, in_coefs, out_ready,
        input  in_ready, out_valid, out_words, out_carry, out_passes, max_passes
    );
    modport slave (
        input  in_valid, in_coefs, out_ready,
        output in_ready, out_valid, out_words, out_carry, out_passes, max_passes
    );
`else
    modport master (
        output in_valid, in_coefs, out_ready,
        input  in_ready, out_valid, out_words, out_carry
    );
    modport slave (
        input  in_valid, in_coefs, out_ready,
        output in_ready, out_valid, out_words, out_carry
    );
`endif

endinterface

// File: rtl/coef_carry_normalizer.sv
// -----------------------------------------------------------------------------
// coef_carry_normalizer
//   Takes NUM_COEFS redundant coefficient sums (BIT_LEN bits each, lane i has
//   weight 2^(i*WORD_LEN)) and ripples the carries one registered pass per
//   cycle until every lane fits in WORD_LEN bits. Carries leaving the top lane
//   are accumulated into out_carry. One operand in flight.
//
//   Ports
//     clk    in  clock, all state on rising edge
//     reset  in  synchronous, active-high
//     bus    coef_carry_normalizer_if.slave (operand in / result out streams)
//
//   Optional feature macro: CARRY_NORM_STATS_EN
//     When defined, bus.out_passes reports the passes taken for the current
//     result and bus.max_passes the running maximum since reset. When
//     undefined, that logic does not exist.
// -----------------------------------------------------------------------------
module coef_carry_normalizer #(
    parameter int NUM_COEFS = 8,
    parameter int BIT_LEN   = 24,
    parameter int WORD_LEN  = 16,
    parameter int CARRY_LEN = BIT_LEN - WORD_LEN + $clog2(NUM_COEFS)
) (
    input  logic                      clk,
    input  logic                      reset,
    coef_carry_normalizer_if.slave    bus
);
    localparam int CW     = BIT_LEN - WORD_LEN;   // per-lane carry width
    localparam int PASS_W = $clog2(NUM_COEFS + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROP,
        S_DONE
    } state_t;

    state_t                             r_state;
    logic                               r_out_valid;
    logic [NUM_COEFS-1:0][BIT_LEN-1:0]  r_coefs;
    logic [CARRY_LEN-1:0]               r_carry_acc;

    logic [NUM_COEFS-1:0][CW-1:0]       w_carry;
    logic [NUM_COEFS-1:0][BIT_LEN-1:0]  w_next;
    logic                               w_any_carry;
    logic                               w_in_ready;
    logic                               w_out_fire;
    logic [NUM_COEFS-1:0][WORD_LEN-1:0] w_out_words;

    // Carry extraction and one parallel propagation pass, all lanes reading
    // the old register values. low + carry < 2^BIT_LEN, so the add is exact.
    always_comb begin
        w_any_carry = 1'b0;
        w_carry     = '0;
        w_next      = '0;
        for (int i = 0; i < NUM_COEFS; i++) begin
            w_carry[i]  = r_coefs[i][BIT_LEN-1:WORD_LEN];
            w_any_carry = w_any_carry | (|w_carry[i]);
        end
        w_next[0] = {{CW{1'b0}}, r_coefs[0][WORD_LEN-1:0]};
        for (int i = 1; i < NUM_COEFS; i++) begin
            w_next[i] = {{CW{1'b0}}, r_coefs[i][WORD_LEN-1:0]}
                      + {{WORD_LEN{1'b0}}, w_carry[i-1]};
        end
    end

    // in_ready must see out_ready in the same cycle to allow back-to-back
    // operands, so it is decoded from registered state rather than registered.
    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign w_out_fire = (r_state == S_DONE) && bus.out_ready;

    always_comb begin
        w_out_words = '0;
        for (int i = 0; i < NUM_COEFS; i++) begin
            w_out_words[i] = r_coefs[i][WORD_LEN-1:0];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_words = w_out_words;
    assign bus.out_carry = r_carry_acc;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // lane update reads pre-edge values and the pass is truly parallel.
    // NOTE: the coefficient registers are reset (not just the control state)
    // because out_words is observed directly from them and must read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_coefs     <= '0;
            r_carry_acc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_coefs     <= bus.in_coefs;
                        r_carry_acc <= '0;
                        r_state     <= S_PROP;
                    end
                end
                S_PROP: begin
                    if (!w_any_carry) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_coefs     <= w_next;
                        r_carry_acc <= r_carry_acc + CARRY_LEN'(w_carry[NUM_COEFS-1]);
                    end
                end
                S_DONE: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            r_coefs     <= bus.in_coefs;
                            r_carry_acc <= '0;
                            r_state     <= S_PROP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CARRY_NORM_STATS_EN
    logic [PASS_W-1:0] r_pass_cnt;
    logic [PASS_W-1:0] r_max_passes;
    logic              w_load;

    assign w_load = w_in_ready && bus.in_valid;

    // Pass counter restarts with every accepted operand; the running maximum
    // is folded in on the PROP -> DONE transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pass_cnt   <= '0;
            r_max_passes <= '0;
        end else begin
            if (w_load) begin
                r_pass_cnt <= '0;
            end else if (r_state == S_PROP) begin
                if (w_any_carry) begin
                    r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                end else if (r_pass_cnt > r_max_passes) begin
                    r_max_passes <= r_pass_cnt;
                end
            end
        end
    end

    assign bus.out_passes = r_pass_cnt;
    assign bus.max_passes = r_max_passes;
`endif

endmodule

// File: tb/tb_coef_carry_normalizer.sv
// -----------------------------------------------------------------------------
// tb_coef_carry_normalizer
//   Self-checking bench for coef_carry_normalizer with NUM_COEFS=4, BIT_LEN=20,
//   WORD_LEN=16, CARRY_LEN=6. Table-driven vectors, hand-written stall /
//   back-to-back / reset sequences, then random operands checked against an
//   arithmetic reference model (whole-operand integer value).
//   Stats checks are compiled in when CARRY_NORM_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_coef_carry_normalizer;
    localparam int NC     = 4;
    localparam int BL     = 20;
    localparam int WL     = 16;
    localparam int CL     = 6;
    localparam int PW     = $clog2(NC + 2);
    localparam int MAXLAT = 40;

    typedef logic [NC-1:0][BL-1:0] coefs_t;
    typedef logic [NC-1:0][WL-1:0] words_t;

    typedef struct {
        string          name;
        coefs_t         coefs;
        words_t         words;
        logic [CL-1:0]  carry;
        int             lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coef_carry_normalizer_if #(
        .NUM_COEFS(NC), .BIT_LEN(BL), .WORD_LEN(WL), .CARRY_LEN(CL)
    ) bus ();

    coef_carry_normalizer #(
        .NUM_COEFS(NC), .BIT_LEN(BL), .WORD_LEN(WL), .CARRY_LEN(CL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_max  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic coefs_t mkc(input int a0, input int a1, input int a2, input int a3);
        coefs_t c;
        c[0] = BL'(a0); c[1] = BL'(a1); c[2] = BL'(a2); c[3] = BL'(a3);
        return c;
    endfunction

    function automatic words_t mkw(input int a0, input int a1, input int a2, input int a3);
        words_t w;
        w[0] = WL'(a0); w[1] = WL'(a1); w[2] = WL'(a2); w[3] = WL'(a3);
        return w;
    endfunction

    // Reference: the operand is one integer; normalized words are its WORD_LEN
    // digits and the carry is everything above them. Pass count comes from
    // repeatedly moving each lane's excess into the next lane.
    function automatic void model(input coefs_t c, output words_t w,
                                  output logic [CL-1:0] cy, output int passes);
        logic [127:0] total;
        longint lane[NC];
        longint nxt[NC];
        bit     any;
        total = '0;
        for (int i = 0; i < NC; i++) total = total + (128'(c[i]) << (i * WL));
        for (int i = 0; i < NC; i++) w[i] = total[i*WL +: WL];
        cy = total[NC*WL +: CL];
        for (int i = 0; i < NC; i++) lane[i] = longint'(c[i]);
        passes = 0;
        for (int k = 0; k < 32; k++) begin
            any = 1'b0;
            for (int i = 0; i < NC; i++) if (lane[i] >= (64'd1 << WL)) any = 1'b1;
            if (!any) break;
            for (int i = 0; i < NC; i++) begin
                nxt[i] = lane[i] % (64'd1 << WL);
                if (i > 0) nxt[i] = nxt[i] + lane[i-1] / (64'd1 << WL);
            end
            lane = nxt;
            passes++;
        end
    endfunction

    task automatic accept(input string name, input coefs_t c);
        int n;
        bus.in_coefs = c;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < MAXLAT) begin
            step();
            n++;
        end
        check({name, " in_ready"}, 128'(bus.in_ready), 128'(1));
        step();
        bus.in_valid = 1'b0;
        bus.in_coefs = coefs_t'({$urandom, $urandom, $urandom});
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < MAXLAT) begin
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string name, input words_t ew,
                                input logic [CL-1:0] ec, input int elat, input int lat);
        check({name, " latency"}, 128'(lat), 128'(elat));
        check({name, " words"}, 128'(bus.out_words), 128'(ew));
        check({name, " carry"}, 128'(bus.out_carry), 128'(ec));
`ifdef CARRY_NORM_STATS_EN
        if (elat - 1 > exp_max) exp_max = elat - 1;
        check({name, " out_passes"}, 128'(bus.out_passes), 128'(elat - 1));
        check({name, " max_passes"}, 128'(bus.max_passes), 128'(exp_max));
`endif
    endtask

    task automatic consume(input string name);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, " out_valid drop"}, 128'(bus.out_valid), 128'(0));
    endtask

    task automatic run_op(input string name, input coefs_t c, input words_t ew,
                          input logic [CL-1:0] ec, input int elat, input int stall);
        int lat;
        accept(name, c);
        wait_valid(lat);
        check_result(name, ew, ec, elat, lat);
        repeat (stall) step();
        consume(name);
    endtask

    vec_t vecs[6];

    initial begin
        int     lat;
        words_t mw;
        logic [CL-1:0] mc;
        int     mp;
        coefs_t rc;

        vecs[0] = '{"t1_ripple",  mkc('h1FFFF, 'hFFFF, 'hFFFF, 'hFFFF),
                    mkw('hFFFF, 0, 0, 0), 6'h01, 5};
        vecs[1] = '{"t2_clean",   mkc(1, 2, 3, 4), mkw(1, 2, 3, 4), 6'h00, 1};
        vecs[2] = '{"t3_allones", mkc('hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF),
                    mkw('hFFFF, 'h000E, 'h000F, 'h000F), 6'h10, 3};
        vecs[3] = '{"lsw_only",   mkc('hFFFFF, 0, 0, 0), mkw('hFFFF, 'hF, 0, 0), 6'h00, 2};
        vecs[4] = '{"msw_only",   mkc(0, 0, 0, 'hFFFFF), mkw(0, 0, 0, 'hFFFF), 6'h0F, 2};
        vecs[5] = '{"ripple_zero", mkc('h10000, 'hFFFF, 'hFFFF, 'hFFFF),
                    mkw(0, 0, 0, 0), 6'h01, 5};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_coefs  = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset in_ready",  128'(bus.in_ready),  128'(1));
        check("reset out_words", 128'(bus.out_words), 128'(0));
        check("reset out_carry", 128'(bus.out_carry), 128'(0));
`ifdef CARRY_NORM_STATS_EN
        check("reset out_passes", 128'(bus.out_passes), 128'(0));
        check("reset max_passes", 128'(bus.max_passes), 128'(0));
`endif

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].name, vecs[v].coefs, vecs[v].words, vecs[v].carry, vecs[v].lat, v % 2);
        end

        // Stall with result held, then back-to-back accept on the out handshake.
        accept("stall", vecs[1].coefs);
        wait_valid(lat);
        check_result("stall first", vecs[1].words, vecs[1].carry, 1, lat);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coefs = coefs_t'({$urandom, $urandom, $urandom});
            #1;
            check("stall in_ready",  128'(bus.in_ready),  128'(0));
            check("stall out_valid", 128'(bus.out_valid), 128'(1));
            check("stall words",     128'(bus.out_words), 128'(vecs[1].words));
            check("stall carry",     128'(bus.out_carry), 128'(vecs[1].carry));
            step();
        end
        bus.in_coefs  = vecs[0].coefs;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("b2b in_ready", 128'(bus.in_ready), 128'(1));
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        wait_valid(lat);
        check_result("b2b second", vecs[0].words, vecs[0].carry, 5, lat);
        consume("b2b second");

        // Reset in the middle of propagation abandons the operand.
        accept("mid_reset", vecs[0].coefs);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_max = 0;
        check("mid_reset out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_reset in_ready",  128'(bus.in_ready),  128'(1));
        check("mid_reset out_words", 128'(bus.out_words), 128'(0));
        check("mid_reset out_carry", 128'(bus.out_carry), 128'(0));
`ifdef CARRY_NORM_STATS_EN
        check("mid_reset max_passes", 128'(bus.max_passes), 128'(0));
`endif
        run_op("after_reset", vecs[2].coefs, vecs[2].words, vecs[2].carry, vecs[2].lat, 0);

        // Random operands against the arithmetic model.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(0, 2))
                    0:       rc[i] = BL'($urandom);
                    1:       rc[i] = BL'(20'hFFFFF - $urandom_range(0, 3));
                    default: rc[i] = BL'($urandom_range(0, 20'h1FFFF));
                endcase
            end
            model(rc, mw, mc, mp);
            run_op("random", rc, mw, mc, mp + 1, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
